// File: rtl/ram_pkg.sv
// Shared types and helpers for the wait-state RAM.
// Optional parity storage is enabled by defining RAM_PARITY_EN.
package ram_pkg;

  localparam int WORD_W_DEF = 8;
  localparam int OP_W_DEF   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } ram_state_t;

  function automatic logic in_window(input int unsigned addr,
                                     input int unsigned base,
                                     input int unsigned depth);
    return (addr >= base) && (addr < base + depth);
  endfunction

endpackage

// File: rtl/wait_state_ram_array.sv
// Single-port word array: synchronous write, combinational read.
// With RAM_PARITY_EN each word carries an even-parity bit checked on read.
module ram_array #(
  parameter int WORD_W = 8,
  parameter int DEPTH  = 10,
  parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clock,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
`ifdef RAM_PARITY_EN
  ,
  output logic              par_err_o
`endif
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  // NOTE: storage arrays get no reset branch; contents are undefined after reset.
  always_ff @(posedge clock) begin
    if (we_i) mem_q[idx_i] <= wdata_i;
  end

  assign rdata_o = mem_q[idx_i];

`ifdef RAM_PARITY_EN
  logic par_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we_i) par_q[idx_i] <= ^wdata_i;
  end

  assign par_err_o = (^mem_q[idx_i]) != par_q[idx_i];

  // Corrupts one stored parity bit so the read-side check can be exercised.
  task automatic flip_parity(input int i);
    par_q[i] = ~par_q[i];
  endtask
`endif

endmodule

// File: rtl/wait_state_ram.sv
// Windowed RAM on the shared sysbus with a programmable wait-state access FSM.
// Define RAM_PARITY_EN to add per-word parity; a read mismatch pulses err with ready.
module wait_state_ram
  import ram_pkg::*;
#(
  parameter int WORD_W      = WORD_W_DEF,
  parameter int OP_W        = OP_W_DEF,
  parameter int BASE        = 20,
  parameter int DEPTH       = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic              MDR_bus,
  input  logic              load_MDR,
  input  logic              load_MAR,
  input  logic              CS,
  input  logic              R_NW,
  inout  wire  [WORD_W-1:0] sysbus,
  output logic              ready,
  output logic              busy,
  output logic              err
);

  localparam int ADDR_W = WORD_W - OP_W;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_WAIT = WAIT;
  localparam logic [1:0] S_DONE = DONE;

  localparam logic [3:0]        WAIT_LOAD = 4'(WAIT_CYCLES);
  localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [WORD_W-1:0] mdr_q, mdr_d;
  logic              op_rd_q, op_rd_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic              hit;
  logic [IDX_W-1:0]  idx;
  logic              mem_we;
  logic [WORD_W-1:0] rdata;

  assign hit = in_window(32'(mar_q), BASE, DEPTH);
  assign idx = IDX_W'(mar_q - BASE_A);

  assign sysbus = (MDR_bus && hit) ? mdr_q : 'z;

`ifdef RAM_PARITY_EN
  logic par_err;
`endif

  ram_array #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clock     (clock),
    .we_i      (mem_we),
    .idx_i     (idx),
    .wdata_i   (mdr_q),
    .rdata_o   (rdata)
`ifdef RAM_PARITY_EN
    ,
    .par_err_o (par_err)
`endif
  );

  // NOTE: every signal written below is defaulted first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    op_rd_d = op_rd_q;
    err_d   = 1'b0;
    mem_we  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (load_MAR) begin
          mar_d = sysbus[ADDR_W-1:0];
        end else if (load_MDR) begin
          mdr_d = sysbus;
        end else if (CS) begin
          if (hit) begin
            op_rd_d = R_NW;
            cnt_d   = WAIT_LOAD;
            state_d = S_WAIT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          if (op_rd_q) begin
            mdr_d = rdata;
`ifdef RAM_PARITY_EN
            err_d = par_err;
`endif
          end else begin
            mem_we = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_DONE);
    busy_d  = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mar_q   <= '0;
      mdr_q   <= '0;
      op_rd_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      op_rd_q <= op_rd_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign err   = err_q;

endmodule

// File: tb/tb_wait_state_ram.sv
// Scoreboard bench for wait_state_ram: one instance with 2 wait states, one with 0.
// Parity-injection cases run only when RAM_PARITY_EN is defined.
module tb_wait_state_ram;

  localparam int WC_A = 2;
  localparam int WC_B = 0;

  typedef struct {
    bit         rdy;
    bit         err;
    bit         chk_data;
    logic [7:0] data;
    int         issue;
    int         lat;
  } ev_t;

  logic clock = 1'b0, n_reset = 1'b0;
  logic mdr_bus = 1'b0, load_mdr = 1'b0, load_mar = 1'b0, r_nw = 1'b0;
  logic cs_a = 1'b0, cs_b = 1'b0, tb_en = 1'b0;
  logic [7:0] tb_drv = 8'h00;

  tri1 [7:0] bus_a, bus_b;
  wire ready_a, busy_a, err_a, ready_b, busy_b, err_b;

  assign bus_a = tb_en ? tb_drv : 8'hzz;
  assign bus_b = tb_en ? tb_drv : 8'hzz;

  int cyc = 0, total = 0, bad = 0;
  ev_t q_a[$], q_b[$];

  wait_state_ram #(.WORD_W(8), .OP_W(3), .BASE(20), .DEPTH(10), .WAIT_CYCLES(WC_A)) u_a (
    .clock(clock), .n_reset(n_reset), .MDR_bus(mdr_bus), .load_MDR(load_mdr),
    .load_MAR(load_mar), .CS(cs_a), .R_NW(r_nw), .sysbus(bus_a),
    .ready(ready_a), .busy(busy_a), .err(err_a));

  wait_state_ram #(.WORD_W(8), .OP_W(3), .BASE(20), .DEPTH(10), .WAIT_CYCLES(WC_B)) u_b (
    .clock(clock), .n_reset(n_reset), .MDR_bus(mdr_bus), .load_MDR(load_mdr),
    .load_MAR(load_mar), .CS(cs_b), .R_NW(r_nw), .sysbus(bus_b),
    .ready(ready_b), .busy(busy_b), .err(err_b));

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per ready/err event and compares it.
  task automatic mon(input int d, input logic r, input logic e, input logic [7:0] b);
    ev_t ev;
    bit  have;
    if (d == 0) begin
      have = (q_a.size() != 0);
      if (have) ev = q_a.pop_front();
    end else begin
      have = (q_b.size() != 0);
      if (have) ev = q_b.pop_front();
    end
    check($sformatf("dut%0d_event_expected", d), 16'(have), 16'd1);
    if (have) begin
      check($sformatf("dut%0d_ready", d), 16'(r), 16'(ev.rdy));
      check($sformatf("dut%0d_err", d), 16'(e), 16'(ev.err));
      check($sformatf("dut%0d_latency", d), 16'(cyc - ev.issue), 16'(ev.lat));
      if (ev.chk_data) check($sformatf("dut%0d_data", d), 16'(b), 16'(ev.data));
    end
  endtask

  always @(negedge clock) begin
    if (ready_a || err_a) mon(0, ready_a, err_a, bus_a);
    if (ready_b || err_b) mon(1, ready_b, err_b, bus_b);
  end

  task automatic load_mar_t(input logic [7:0] v);
    tb_drv = v; tb_en = 1'b1; load_mar = 1'b1;
    @(posedge clock); #1;
    load_mar = 1'b0; tb_en = 1'b0;
  endtask

  task automatic load_mdr_t(input logic [7:0] v);
    tb_drv = v; tb_en = 1'b1; load_mdr = 1'b1;
    @(posedge clock); #1;
    load_mdr = 1'b0; tb_en = 1'b0;
  endtask

  task automatic push(input int d, input bit hit, input bit perr, input logic [7:0] exp_data);
    ev_t ev;
    ev.rdy      = hit;
    ev.err      = !hit || perr;
    ev.chk_data = hit;
    ev.data     = exp_data;
    ev.issue    = cyc + 1;
    ev.lat      = hit ? ((d == 0) ? WC_A + 1 : WC_B + 1) : 0;
    if (d == 0) q_a.push_back(ev);
    else        q_b.push_back(ev);
  endtask

  task automatic wait_idle(input int d);
    bit ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clock); #1;
      if (d == 0) ok = !busy_a && !ready_a && !err_a;
      else        ok = !busy_b && !ready_b && !err_b;
    end
    check($sformatf("dut%0d_idle_in_time", d), 16'(ok), 16'd1);
  endtask

  task automatic start_cs(input int d, input bit rd);
    r_nw = rd;
    if (d == 0) cs_a = 1'b1; else cs_b = 1'b1;
    @(posedge clock); #1;
    cs_a = 1'b0; cs_b = 1'b0;
    r_nw = ~rd;
  endtask

  // Full access; reads preload mdr with 0 so returned data must come from memory.
  task automatic access(input int d, input logic [7:0] addr, input bit rd,
                        input logic [7:0] wdata, input bit hit, input bit perr,
                        input logic [7:0] exp_data);
    load_mar_t(addr);
    load_mdr_t(rd ? 8'h00 : wdata);
    push(d, hit, perr, exp_data);
    start_cs(d, rd);
    mdr_bus = 1'b1;
    wait_idle(d);
    mdr_bus = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst_busy_a", 16'(busy_a), 16'd0);
    check("rst_ready_a", 16'(ready_a), 16'd0);
    check("rst_err_a", 16'(err_a), 16'd0);
    check("rst_busy_b", 16'(busy_b), 16'd0);
    mdr_bus = 1'b1; #1;
    check("rst_bus_released", 16'(bus_a), 16'hff);
    mdr_bus = 1'b0;
    n_reset = 1'b1;
    @(posedge clock); #1;

    // Bus tri-state versus window hit
    load_mar_t(8'd5);
    mdr_bus = 1'b1; #1;
    check("bus_miss_released", 16'(bus_a), 16'hff);
    mdr_bus = 1'b0;
    load_mar_t(8'd25);
    mdr_bus = 1'b1; #1;
    check("bus_hit_rst_mdr", 16'(bus_a), 16'h00);
    mdr_bus = 1'b0;
    load_mdr_t(8'h96);
    mdr_bus = 1'b1; #1;
    check("bus_hit_mdr", 16'(bus_a), 16'h96);
    mdr_bus = 1'b0;

    // Write then read
    access(0, 8'd21, 1'b0, 8'hA5, 1'b1, 1'b0, 8'hA5);
    access(0, 8'd21, 1'b1, 8'h00, 1'b1, 1'b0, 8'hA5);

    // Window edges: hits at both ends, misses just outside
    access(0, 8'd20, 1'b0, 8'h3A, 1'b1, 1'b0, 8'h3A);
    access(0, 8'd29, 1'b0, 8'hC5, 1'b1, 1'b0, 8'hC5);
    access(0, 8'd19, 1'b0, 8'hEE, 1'b0, 1'b0, 8'h00);
    access(0, 8'd30, 1'b0, 8'hEE, 1'b0, 1'b0, 8'h00);
    access(0, 8'd20, 1'b1, 8'h00, 1'b1, 1'b0, 8'h3A);
    access(0, 8'd29, 1'b1, 8'h00, 1'b1, 1'b0, 8'hC5);
    access(0, 8'd21, 1'b1, 8'h00, 1'b1, 1'b0, 8'hA5);

    // Busy lockout: MAR/MDR loads during WAIT must be ignored
    access(0, 8'd28, 1'b0, 8'h77, 1'b1, 1'b0, 8'h77);
    load_mar_t(8'd23);
    load_mdr_t(8'h5A);
    push(0, 1'b1, 1'b0, 8'h5A);
    start_cs(0, 1'b0);
    load_mar_t(8'h1C);
    load_mdr_t(8'hFF);
    mdr_bus = 1'b1;
    wait_idle(0);
    mdr_bus = 1'b0;
    access(0, 8'd28, 1'b1, 8'h00, 1'b1, 1'b0, 8'h77);
    access(0, 8'd23, 1'b1, 8'h00, 1'b1, 1'b0, 8'h5A);

    // Reset in the middle of a write
    access(0, 8'd22, 1'b0, 8'h11, 1'b1, 1'b0, 8'h11);
    load_mar_t(8'd22);
    load_mdr_t(8'h3C);
    start_cs(0, 1'b0);
    @(posedge clock); #1;
    check("midwrite_busy_before", 16'(busy_a), 16'd1);
    n_reset = 1'b0; #1;
    check("midwrite_busy_after_rst", 16'(busy_a), 16'd0);
    check("midwrite_ready_after_rst", 16'(ready_a), 16'd0);
    @(posedge clock); #1;
    n_reset = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    access(0, 8'd22, 1'b1, 8'h00, 1'b1, 1'b0, 8'h11);

    // Zero wait states
    access(1, 8'd24, 1'b0, 8'h4B, 1'b1, 1'b0, 8'h4B);
    access(1, 8'd24, 1'b1, 8'h00, 1'b1, 1'b0, 8'h4B);
`ifdef RAM_PARITY_EN
    u_b.u_array.flip_parity(4);
    access(1, 8'd24, 1'b1, 8'h00, 1'b1, 1'b1, 8'h4B);
`endif

    repeat (3) @(posedge clock);
    #1;
    check("sb_a_drained", 16'(q_a.size()), 16'd0);
    check("sb_b_drained", 16'(q_b.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
